// File: rtl/sift_rot_pkg.sv
// Shared types, default parameters and width helper for the SIFT rotated-coordinate generator.
package sift_rot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIN     = 16;
  localparam int DEF_NUM_ORI = 36;
  localparam int DEF_FRAC    = 8;
  localparam int DEF_COORD_W = 5;

  // Index width for n entries, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sift_trig_rom.sv
// Orientation bin -> {cos, sin} in signed Q1.FRAC. Table is 36 bins of 10 deg, stored in Q1.8
// and rescaled to FRAC at elaboration.
module sift_trig_rom
  import sift_rot_pkg::*;
#(
  parameter int NUM_ORI = DEF_NUM_ORI,
  parameter int FRAC    = DEF_FRAC,
  parameter int OW      = bits_for(NUM_ORI)
) (
  input  logic        [OW-1:0]   ori,
  output logic signed [FRAC+1:0] cos_q,
  output logic signed [FRAC+1:0] sin_q
);

  localparam int TW = FRAC + 2;
  localparam int UP = (FRAC >= 8) ? FRAC - 8 : 0;
  localparam int DN = (FRAC < 8) ? 8 - FRAC : 0;

  int c8;
  int s8;

  always_comb begin
    c8 = 0;
    s8 = 0;
    case (int'(ori))
      0:  begin c8 =  256; s8 =    0; end
      1:  begin c8 =  252; s8 =   44; end
      2:  begin c8 =  241; s8 =   88; end
      3:  begin c8 =  222; s8 =  128; end
      4:  begin c8 =  196; s8 =  165; end
      5:  begin c8 =  165; s8 =  196; end
      6:  begin c8 =  128; s8 =  222; end
      7:  begin c8 =   88; s8 =  241; end
      8:  begin c8 =   44; s8 =  252; end
      9:  begin c8 =    0; s8 =  256; end
      10: begin c8 =  -44; s8 =  252; end
      11: begin c8 =  -88; s8 =  241; end
      12: begin c8 = -128; s8 =  222; end
      13: begin c8 = -165; s8 =  196; end
      14: begin c8 = -196; s8 =  165; end
      15: begin c8 = -222; s8 =  128; end
      16: begin c8 = -241; s8 =   88; end
      17: begin c8 = -252; s8 =   44; end
      18: begin c8 = -256; s8 =    0; end
      19: begin c8 = -252; s8 =  -44; end
      20: begin c8 = -241; s8 =  -88; end
      21: begin c8 = -222; s8 = -128; end
      22: begin c8 = -196; s8 = -165; end
      23: begin c8 = -165; s8 = -196; end
      24: begin c8 = -128; s8 = -222; end
      25: begin c8 =  -88; s8 = -241; end
      26: begin c8 =  -44; s8 = -252; end
      27: begin c8 =    0; s8 = -256; end
      28: begin c8 =   44; s8 = -252; end
      29: begin c8 =   88; s8 = -241; end
      30: begin c8 =  128; s8 = -222; end
      31: begin c8 =  165; s8 = -196; end
      32: begin c8 =  196; s8 = -165; end
      33: begin c8 =  222; s8 = -128; end
      34: begin c8 =  241; s8 =  -88; end
      35: begin c8 =  252; s8 =  -44; end
      default: begin c8 = 0; s8 = 0; end
    endcase
    cos_q = TW'((c8 <<< UP) >>> DN);
    sin_q = TW'((s8 <<< UP) >>> DN);
  end

endmodule

// File: rtl/sift_rot_coord_gen.sv
// Scans a WIN x WIN window in raster order and streams rotated, rounded, saturated
// coordinates (x', y') with the source (row, col) through a 3-stage stallable pipeline.
module sift_rot_coord_gen
  import sift_rot_pkg::*;
#(
  parameter int WIN     = DEF_WIN,
  parameter int NUM_ORI = DEF_NUM_ORI,
  parameter int FRAC    = DEF_FRAC,
  parameter int COORD_W = DEF_COORD_W,
  localparam int CW     = bits_for(WIN),
  localparam int OW     = bits_for(NUM_ORI)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      start_ready,
  input  logic        [OW-1:0]      ori,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COORD_W-1:0] out_x,
  output logic signed [COORD_W-1:0] out_y,
  output logic        [CW-1:0]      out_row,
  output logic        [CW-1:0]      out_col,
  output logic                      out_last,
  output logic                      done,
  output logic                      ori_err,
  output state_t                    fsm_state
);

  localparam int UW = CW + 2;
  localparam int TW = FRAC + 2;
  localparam int PW = UW + TW;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] HALF = SW'(2 ** FRAC);
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (COORD_W - 1) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (COORD_W - 1)));

  state_t state, next_state;
  logic        [CW-1:0] row_q, col_q;
  logic        [OW-1:0] ori_q;
  logic signed [TW-1:0] cos_v, sin_v;
  logic signed [UW-1:0] u, v;
  logic en, accept, s0_valid, s0_last, last_xfer;
  logic s1_valid, s1_last;
  logic        [CW-1:0] s1_row, s1_col;
  logic signed [PW-1:0] s1_uc, s1_us, s1_vc, s1_vs;
  logic signed [SW-1:0] px, py, rx, ry;
  logic signed [COORD_W-1:0] sat_x, sat_y;

  // Handshake: a sample transfers on a clock edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, every stage, counter and output holds.
  assign en        = !out_valid || out_ready;
  assign s0_valid  = (state == RUN);
  assign s0_last   = (row_q == CW'(WIN - 1)) && (col_q == CW'(WIN - 1));
  assign last_xfer = out_valid && out_ready && out_last;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN:     if (en && s0_last) next_state = DRAIN;
      DRAIN:   if (last_xfer) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // S0: raster counters and orientation latch; an out-of-range bin falls back to bin 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      ori_q   <= '0;
      ori_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      ori_err <= 1'b0;
      done    <= last_xfer;
      if (accept) begin
        row_q <= '0;
        col_q <= '0;
        if ({1'b0, ori} >= (OW + 1)'(NUM_ORI)) begin
          ori_q   <= '0;
          ori_err <= 1'b1;
        end else begin
          ori_q <= ori;
        end
      end else if (s0_valid && en) begin
        col_q <= col_q + CW'(1);
        if (col_q == CW'(WIN - 1)) row_q <= row_q + CW'(1);
      end
    end
  end

  sift_trig_rom #(
    .NUM_ORI (NUM_ORI),
    .FRAC    (FRAC),
    .OW      (OW)
  ) u_rom (
    .ori   (ori_q),
    .cos_q (cos_v),
    .sin_q (sin_v)
  );

  // Half-pixel offsets from the window centre: odd values in [-(WIN-1), WIN-1].
  assign u = {1'b0, col_q, 1'b0} - UW'(WIN - 1);
  assign v = {1'b0, row_q, 1'b0} - UW'(WIN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_uc    <= '0;
      s1_us    <= '0;
      s1_vc    <= '0;
      s1_vs    <= '0;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_last  <= s0_valid && s0_last;
      s1_row   <= row_q;
      s1_col   <= col_q;
      s1_uc    <= PW'(u) * PW'(cos_v);
      s1_us    <= PW'(u) * PW'(sin_v);
      s1_vc    <= PW'(v) * PW'(cos_v);
      s1_vs    <= PW'(v) * PW'(sin_v);
    end
  end

  function automatic logic signed [COORD_W-1:0] sat(input logic signed [SW-1:0] val);
    if (val > MAXV)      return MAXV[COORD_W-1:0];
    else if (val < MINV) return MINV[COORD_W-1:0];
    else                 return val[COORD_W-1:0];
  endfunction

  // S2: offsets carry one extra fraction bit, so the shift is FRAC+1 with a 2^FRAC bias.
  always_comb begin
    px    = SW'(s1_uc) + SW'(s1_vs);
    py    = SW'(s1_vc) - SW'(s1_us);
    rx    = (px + HALF) >>> (FRAC + 1);
    ry    = (py + HALF) >>> (FRAC + 1);
    sat_x = sat(rx);
    sat_y = sat(ry);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_last  <= s1_last;
      out_row   <= s1_row;
      out_col   <= s1_col;
      out_x     <= sat_x;
      out_y     <= sat_y;
    end
  end

endmodule

// File: tb/tb_sift_rot_coord_gen.sv
// Bench for sift_rot_coord_gen: trig-derived golden model feeding a scoreboard, with a
// second instance at COORD_W=4 driven in lockstep to exercise saturation.
module tb_sift_rot_coord_gen;
  import sift_rot_pkg::*;

  localparam int  WIN  = 16;
  localparam int  NORI = 36;
  localparam int  EW   = 27;
  localparam real PI   = 3.14159265358979;

  typedef struct packed {
    logic        [3:0] row;
    logic        [3:0] col;
    logic signed [4:0] x;
    logic signed [4:0] y;
    logic signed [3:0] x4;
    logic signed [3:0] y4;
    logic              last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic [5:0] ori = '0;

  logic start_ready, out_valid, out_last, done, ori_err;
  logic signed [4:0] out_x, out_y;
  logic [3:0] out_row, out_col;
  state_t fsm_state;

  logic start_ready4, out_valid4, out_last4, done4, ori_err4;
  logic signed [3:0] out_x4, out_y4;
  logic [3:0] out_row4, out_col4;
  state_t fsm_state4;

  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  bit done_due = 0;
  bit err_due = 0;
  logic [EW-1:0] exp_q[$];
  exp_t me;
  int cap_x[16][16], cap_y[16][16], cap_x4[16][16], cap_y4[16][16];

  always #5 clk = ~clk;

  sift_rot_coord_gen dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .ori(ori),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done),
    .ori_err(ori_err), .fsm_state(fsm_state)
  );

  sift_rot_coord_gen #(.COORD_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready4), .ori(ori),
    .out_valid(out_valid4), .out_ready(out_ready), .out_x(out_x4), .out_y(out_y4),
    .out_row(out_row4), .out_col(out_col4), .out_last(out_last4), .done(done4),
    .ori_err(ori_err4), .fsm_state(fsm_state4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
  endfunction

  function automatic int model_coord(input int o, input int r, input int c,
                                     input bit is_y, input int cw);
    real th;
    int cq, sq, u, v, p, q, hi, lo;
    th = real'(o) * 2.0 * PI / real'(NORI);
    cq = rnd(256.0 * $cos(th));
    sq = rnd(256.0 * $sin(th));
    u  = 2 * c - (WIN - 1);
    v  = 2 * r - (WIN - 1);
    p  = is_y ? (v * cq - u * sq) : (u * cq + v * sq);
    q  = (p + 256) >>> 9;
    hi = (1 << (cw - 1)) - 1;
    lo = -(1 << (cw - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic push_scan(input int o_raw);
    exp_t e;
    int o;
    o = (o_raw >= NORI) ? 0 : o_raw;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        e.row  = r[3:0];
        e.col  = c[3:0];
        e.x    = 5'(model_coord(o, r, c, 1'b0, 5));
        e.y    = 5'(model_coord(o, r, c, 1'b1, 5));
        e.x4   = 4'(model_coord(o, r, c, 1'b0, 4));
        e.y4   = 4'(model_coord(o, r, c, 1'b1, 4));
        e.last = (r == WIN - 1) && (c == WIN - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      done_due = 0;
      err_due  = 0;
      xfer_cnt = 0;
    end else begin
      check("done", done, done_due);
      check("done4", done4, done_due);
      done_due = 0;
      check("ori_err", ori_err, err_due);
      check("ori_err4", ori_err4, err_due);
      err_due = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          me = exp_q.pop_front();
          check("row", out_row, me.row);
          check("col", out_col, me.col);
          check("x", out_x, me.x);
          check("y", out_y, me.y);
          check("last", out_last, me.last);
          check("valid4", out_valid4, 1);
          check("row4", out_row4, me.row);
          check("col4", out_col4, me.col);
          check("x4", out_x4, me.x4);
          check("y4", out_y4, me.y4);
          check("last4", out_last4, me.last);
          cap_x[out_row][out_col]  = out_x;
          cap_y[out_row][out_col]  = out_y;
          cap_x4[out_row][out_col] = out_x4;
          cap_y4[out_row][out_col] = out_y4;
          xfer_cnt++;
          if (out_last) begin
            check("xfer_count", xfer_cnt, WIN * WIN);
            done_due = 1;
            xfer_cnt = 0;
          end
        end
      end
      if (start && start_ready) begin
        push_scan(int'(ori));
        err_due = (int'(ori) >= NORI);
      end
    end
  end

  task automatic do_start(input int o);
    start = 1'b1;
    ori   = o[5:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    check({tag, "_lat0"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, out_valid, 1);
  endtask

  task automatic wait_done(input string tag, input bit rand_ready);
    bit got;
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1;
        break;
      end
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    check(tag, got, 1);
  endtask

  task automatic wait_xfers(input string tag, input int n);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (xfer_cnt >= n) break;
    end
    check(tag, xfer_cnt, n);
  endtask

  initial begin
    exp_t pk;
    bit got;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_ready", start_ready, 1);
    check("rst_ready4", start_ready4, 1);
    check("rst_done", done, 0);
    check("rst_err", ori_err, 0);
    check("rst_x", out_x, 0);
    check("rst_row", out_row, 0);
    check("rst_last", out_last, 0);
    check("rst_state", fsm_state, IDLE);
    check("rst_state4", fsm_state4, IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0 deg
    do_start(0);
    check_latency("s1");
    wait_done("s1_done", 1'b0);
    check("s1_x00", cap_x[0][0], -7);
    check("s1_y00", cap_y[0][0], -7);
    check("s1_x015", cap_x[0][15], 8);
    check("s1_y015", cap_y[0][15], -7);

    // 90 deg
    do_start(9);
    wait_done("s2_done", 1'b0);
    check("s2_x015", cap_x[0][15], -7);
    check("s2_y015", cap_y[0][15], -7);
    check("s2_x150", cap_x[15][0], 8);
    check("s2_y150", cap_y[15][0], 8);

    // 180 deg, with saturation on the narrow instance
    do_start(18);
    wait_done("s3_done", 1'b0);
    check("s3_x00", cap_x[0][0], 8);
    check("s3_y00", cap_y[0][0], 8);
    check("s3_x00_w4", cap_x4[0][0], 7);
    check("s3_y00_w4", cap_y4[0][0], 7);

    // Five-cycle stall at sample 100
    do_start(5);
    wait_xfers("s4_reach100", 100);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      pk = exp_q[0];
      check("stall_valid", out_valid, 1);
      check("stall_row", out_row, pk.row);
      check("stall_col", out_col, pk.col);
      check("stall_x", out_x, pk.x);
      check("stall_y", out_y, pk.y);
    end
    out_ready = 1'b1;
    wait_done("s4a_done", 1'b0);

    // Random backpressure
    do_start(27);
    wait_done("s4b_done", 1'b1);

    // Bad ori, ignored start mid-scan, back-to-back start on done
    do_start(40);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    ori   = 6'd9;
    check("busy_ready", start_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_ready && out_last) begin
        got = 1;
        break;
      end
    end
    check("s5_last_seen", got, 1);
    @(posedge clk); #1;
    check("b2b_done", done, 1);
    check("b2b_ready", start_ready, 1);
    do_start(18);
    check_latency("b2b");
    wait_done("s5_done", 1'b0);

    // Reset mid-scan
    do_start(3);
    wait_xfers("s6_reach37", 37);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", start_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_last", out_last, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 0);
    do_start(0);
    check_latency("s6");
    check("s6_row0", out_row, 0);
    check("s6_col0", out_col, 0);
    wait_done("s6_done", 1'b0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
